param_access_arbiter: RTL and testbench

//  Owns the interval-time parameter store (4 x 4-bit) and shares its single access port

---
 rtl/param_access_arbiter_pkg.sv | 38 +++
 rtl/param_access_arbiter_store.sv | 44 ++++
 rtl/param_access_arbiter.sv | 141 ++++++++++++++
 tb/tb_param_access_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/param_access_arbiter_pkg.sv
// Shared definitions for the interval-time parameter store and its access arbiter.
package param_access_arbiter_pkg;

   localparam int unsigned DATA_W      = 4;
   localparam int unsigned ADDR_W      = 2;
   localparam int unsigned NUM_ENTRIES = 4;
   localparam int unsigned WAIT_W      = 2;

   localparam logic [ADDR_W-1:0] ADDR_BASE = 2'b00;
   localparam logic [ADDR_W-1:0] ADDR_EXT  = 2'b01;
   localparam logic [ADDR_W-1:0] ADDR_YEL  = 2'b10;
   localparam logic [ADDR_W-1:0] ADDR_WALK = 2'b11;

   localparam logic [DATA_W-1:0] T_BASE = 4'd6;
   localparam logic [DATA_W-1:0] T_EXT  = 4'd3;
   localparam logic [DATA_W-1:0] T_YEL  = 4'd2;
   localparam logic [DATA_W-1:0] T_WALK = 4'd3;

   localparam logic [WAIT_W-1:0] WAIT_MAX = '1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SERVE_WR,
      ST_SERVE_RD,
      ST_SERVE_DBG,
      ST_RESTORE
   } arb_state_e;

   function automatic logic [DATA_W-1:0] default_time(input logic [ADDR_W-1:0] addr);
      case (addr)
         ADDR_BASE: return T_BASE;
         ADDR_EXT:  return T_EXT;
         ADDR_YEL:  return T_YEL;
         default:   return T_WALK;
      endcase
   endfunction

endpackage

// File: rtl/param_access_arbiter_store.sv
// 4x4 parameter register file: one write port, one combinational read port,
// parallel reload of all defaults.
module param_access_arbiter_store
   import param_access_arbiter_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              restore,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata_c
);

   logic [DATA_W-1:0] mem_q [NUM_ENTRIES];
   logic [DATA_W-1:0] mem_d [NUM_ENTRIES];

   // Restore wins over a write; the arbiter never issues both together.
   always_comb begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         if (restore) begin
            mem_d[i] = default_time(ADDR_W'(i));
         end else if (we && (waddr == ADDR_W'(i))) begin
            mem_d[i] = wdata;
         end else begin
            mem_d[i] = mem_q[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            mem_q[i] <= default_time(ADDR_W'(i));
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rdata_c = mem_q[raddr];

endmodule

// File: rtl/param_access_arbiter.sv
// Arbitrates the single parameter-store port among reprogram writes, FSM lookups
// and diagnostic reads, with a starvation guard for the diagnostic port.
module param_access_arbiter
   import param_access_arbiter_pkg::*;
(
   input  logic              clk,
   input  logic              sys_reset_n,
   input  logic              restore,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ack,
   output logic              wr_clamped,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_ack,
   output logic [DATA_W-1:0] rd_data,
   input  logic              dbg_req,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic              dbg_ack,
   output logic [DATA_W-1:0] dbg_data,
   output logic              param_changed
);

   arb_state_e        state_q, state_d;
   logic              restore_pend_q, restore_pend_d;
   logic [WAIT_W-1:0] dbg_wait_q, dbg_wait_d;
   logic              wr_ack_q, wr_ack_d;
   logic              wr_clamped_q, wr_clamped_d;
   logic              rd_ack_q, rd_ack_d;
   logic              dbg_ack_q, dbg_ack_d;
   logic              param_changed_q, param_changed_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic [DATA_W-1:0] dbg_data_q, dbg_data_d;

   logic              st_we_c, st_restore_c, dbg_pick_c;
   logic [ADDR_W-1:0] st_raddr_c;
   logic [DATA_W-1:0] st_rdata_c, st_wdata_c;

   // Debug wins when starved, or when it is the only requester.
   assign dbg_pick_c = dbg_req && ((dbg_wait_q == WAIT_MAX) || (!wr_req && !rd_req));
   assign st_raddr_c = dbg_pick_c ? dbg_addr : rd_addr;
   assign st_wdata_c = (wr_data == '0) ? DATA_W'(1) : wr_data;

   always_comb begin
      state_d         = state_q;
      restore_pend_d  = restore_pend_q;
      dbg_wait_d      = dbg_wait_q;
      wr_ack_d        = 1'b0;
      wr_clamped_d    = 1'b0;
      rd_ack_d        = 1'b0;
      dbg_ack_d       = 1'b0;
      rd_data_d       = rd_data_q;
      dbg_data_d      = dbg_data_q;
      st_we_c         = 1'b0;
      st_restore_c    = 1'b0;
      param_changed_d = (state_q == ST_SERVE_WR) || (state_q == ST_RESTORE);

      case (state_q)
         ST_IDLE: begin
            if (restore || restore_pend_q) begin
               state_d        = ST_RESTORE;
               st_restore_c   = 1'b1;
               restore_pend_d = 1'b0;
            end else if (dbg_pick_c) begin
               state_d    = ST_SERVE_DBG;
               dbg_ack_d  = 1'b1;
               dbg_data_d = st_rdata_c;
               dbg_wait_d = '0;
            end else if (wr_req || rd_req) begin
               if (wr_req) begin
                  state_d      = ST_SERVE_WR;
                  wr_ack_d     = 1'b1;
                  wr_clamped_d = (wr_data == '0);
                  st_we_c      = 1'b1;
               end else begin
                  state_d   = ST_SERVE_RD;
                  rd_ack_d  = 1'b1;
                  rd_data_d = st_rdata_c;
               end
               if (dbg_req && (dbg_wait_q != WAIT_MAX)) begin
                  dbg_wait_d = dbg_wait_q + WAIT_W'(1);
               end
            end
         end
         default: begin
            // Every serve/restore state lasts one cycle; late restores are parked.
            state_d = ST_IDLE;
            if (restore) begin
               restore_pend_d = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         state_q         <= ST_IDLE;
         restore_pend_q  <= 1'b0;
         dbg_wait_q      <= '0;
         wr_ack_q        <= 1'b0;
         wr_clamped_q    <= 1'b0;
         rd_ack_q        <= 1'b0;
         dbg_ack_q       <= 1'b0;
         param_changed_q <= 1'b0;
         rd_data_q       <= '0;
         dbg_data_q      <= '0;
      end else begin
         state_q         <= state_d;
         restore_pend_q  <= restore_pend_d;
         dbg_wait_q      <= dbg_wait_d;
         wr_ack_q        <= wr_ack_d;
         wr_clamped_q    <= wr_clamped_d;
         rd_ack_q        <= rd_ack_d;
         dbg_ack_q       <= dbg_ack_d;
         param_changed_q <= param_changed_d;
         rd_data_q       <= rd_data_d;
         dbg_data_q      <= dbg_data_d;
      end
   end

   param_access_arbiter_store u_store (
      .clk     (clk),
      .rst_n   (sys_reset_n),
      .restore (st_restore_c),
      .we      (st_we_c),
      .waddr   (wr_addr),
      .wdata   (st_wdata_c),
      .raddr   (st_raddr_c),
      .rdata_c (st_rdata_c)
   );

   assign wr_ack        = wr_ack_q;
   assign wr_clamped    = wr_clamped_q;
   assign rd_ack        = rd_ack_q;
   assign rd_data       = rd_data_q;
   assign dbg_ack       = dbg_ack_q;
   assign dbg_data      = dbg_data_q;
   assign param_changed = param_changed_q;

endmodule

// File: tb/tb_param_access_arbiter.sv
// Self-checking bench for param_access_arbiter: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a behavioural model.
module tb_param_access_arbiter;

   logic       clk = 1'b0;
   logic       sys_reset_n = 1'b0;
   logic       restore = 1'b0;
   logic       wr_req = 1'b0;
   logic [1:0] wr_addr = 2'd0;
   logic [3:0] wr_data = 4'd0;
   logic       wr_ack, wr_clamped;
   logic       rd_req = 1'b0;
   logic [1:0] rd_addr = 2'd0;
   logic       rd_ack;
   logic [3:0] rd_data;
   logic       dbg_req = 1'b0;
   logic [1:0] dbg_addr = 2'd0;
   logic       dbg_ack;
   logic [3:0] dbg_data;
   logic       param_changed;

   param_access_arbiter dut (
      .clk(clk), .sys_reset_n(sys_reset_n), .restore(restore),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_ack(wr_ack), .wr_clamped(wr_clamped),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
      .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_ack(dbg_ack), .dbg_data(dbg_data),
      .param_changed(param_changed)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   localparam int K_IDLE = 0, K_WR = 1, K_RD = 2, K_DBG = 3, K_RST = 4;
   logic [3:0] m_store [4];
   int         m_kind;       // what the block is doing this cycle
   bit         m_pend;       // restore seen while busy
   int         m_wait;       // wr/rd grants taken while debug was waiting
   logic       e_wr_ack, e_clamp, e_rd_ack, e_dbg_ack, e_pc;
   logic [3:0] e_rd_data, e_dbg_data;

   task automatic m_reset();
      m_store[0] = 4'd6; m_store[1] = 4'd3; m_store[2] = 4'd2; m_store[3] = 4'd3;
      m_kind = K_IDLE; m_pend = 0; m_wait = 0;
      e_wr_ack = 0; e_clamp = 0; e_rd_ack = 0; e_dbg_ack = 0; e_pc = 0;
      e_rd_data = 0; e_dbg_data = 0;
   endtask

   task automatic m_grant_dbg();
      e_dbg_ack = 1; e_dbg_data = m_store[dbg_addr]; m_wait = 0; m_kind = K_DBG;
   endtask

   task automatic m_step();
      int prev = m_kind;
      e_pc = (prev == K_WR) || (prev == K_RST);
      e_wr_ack = 0; e_rd_ack = 0; e_dbg_ack = 0; e_clamp = 0;
      if (prev != K_IDLE) begin
         if (restore) m_pend = 1;
         m_kind = K_IDLE;
      end else if (restore || m_pend) begin
         m_store[0] = 4'd6; m_store[1] = 4'd3; m_store[2] = 4'd2; m_store[3] = 4'd3;
         m_pend = 0; m_kind = K_RST;
      end else if (dbg_req && m_wait >= 3) begin
         m_grant_dbg();
      end else if (wr_req) begin
         e_wr_ack = 1; e_clamp = (wr_data == 0);
         m_store[wr_addr] = (wr_data == 0) ? 4'd1 : wr_data;
         if (dbg_req && m_wait < 3) m_wait++;
         m_kind = K_WR;
      end else if (rd_req) begin
         e_rd_ack = 1; e_rd_data = m_store[rd_addr];
         if (dbg_req && m_wait < 3) m_wait++;
         m_kind = K_RD;
      end else if (dbg_req) begin
         m_grant_dbg();
      end
   endtask

   initial begin
      m_reset();
      forever begin
         @(posedge clk or negedge sys_reset_n);
         if (!sys_reset_n) m_reset();
         else m_step();
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         chk("wr_ack", 4'(wr_ack), 4'(e_wr_ack));
         chk("rd_ack", 4'(rd_ack), 4'(e_rd_ack));
         chk("dbg_ack", 4'(dbg_ack), 4'(e_dbg_ack));
         chk("param_changed", 4'(param_changed), 4'(e_pc));
         chk("rd_data", rd_data, e_rd_data);
         chk("dbg_data", dbg_data, e_dbg_data);
         if (e_wr_ack) chk("wr_clamped", 4'(wr_clamped), 4'(e_clamp));
      end
   end

   // ---------------- directed helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_dbg(input logic [1:0] a, output logic [3:0] d, output int lat);
      dbg_req = 1; dbg_addr = a; lat = 0;
      do begin tick(); lat++; end while (!dbg_ack && lat < 10);
      chk("dbg_ack_seen", 4'(dbg_ack), 4'd1);
      d = dbg_data; dbg_req = 0;
      tick();
   endtask

   task automatic do_rd(input logic [1:0] a, output logic [3:0] d);
      int n = 0;
      rd_req = 1; rd_addr = a;
      do begin tick(); n++; end while (!rd_ack && n < 10);
      chk("rd_ack_seen", 4'(rd_ack), 4'd1);
      d = rd_data; rd_req = 0;
      tick();
   endtask

   task automatic do_wr(input logic [1:0] a, input logic [3:0] dt, output logic cl);
      int n = 0;
      wr_req = 1; wr_addr = a; wr_data = dt;
      do begin tick(); n++; end while (!wr_ack && n < 10);
      chk("wr_ack_seen", 4'(wr_ack), 4'd1);
      chk("wr_latency", 4'(n), 4'd1);
      cl = wr_clamped; wr_req = 0;
      tick();
      chk("pc_after_wr", 4'(param_changed), 4'd1);
   endtask

   // ---------------- stimulus ----------------
   initial begin : main
      logic [3:0] d;
      logic       cl;
      int         lat, t_wr, t_rd, t_dbg, g, g_dbg;
      logic [3:0] dflt [4];
      dflt[0] = 4'd6; dflt[1] = 4'd3; dflt[2] = 4'd2; dflt[3] = 4'd3;

      repeat (3) tick();
      chk("rst_wr_ack", 4'(wr_ack), 4'd0);
      chk("rst_rd_data", rd_data, 4'd0);
      chk("rst_dbg_data", dbg_data, 4'd0);
      chk("rst_pc", 4'(param_changed), 4'd0);
      sys_reset_n = 1;
      tick();

      // defaults via the diagnostic port, 1-cycle latency each
      for (int a = 0; a < 4; a++) begin
         do_dbg(2'(a), d, lat);
         chk("dflt_dbg", d, dflt[a]);
         chk("dbg_latency", 4'(lat), 4'd1);
      end

      do_wr(2'd2, 4'd9, cl);
      chk("wr9_clamp", 4'(cl), 4'd0);
      do_rd(2'd2, d);
      chk("rd_after_wr9", d, 4'd9);

      // all three at once: WR, RD, DBG, two cycles apart
      wr_req = 1; wr_addr = 2'd0; wr_data = 4'd7;
      rd_req = 1; rd_addr = 2'd0;
      dbg_req = 1; dbg_addr = 2'd1;
      t_wr = 0; t_rd = 0; t_dbg = 0;
      for (int t = 1; t <= 8; t++) begin
         tick();
         if (wr_ack)  begin t_wr = t;  wr_req = 0;  end
         if (rd_ack)  begin t_rd = t;  rd_req = 0;  chk("simul_rd", rd_data, 4'd7); end
         if (dbg_ack) begin t_dbg = t; dbg_req = 0; end
      end
      chk("order_wr", 4'(t_wr), 4'd1);
      chk("order_rd", 4'(t_rd), 4'd3);
      chk("order_dbg", 4'(t_dbg), 4'd5);

      do_wr(2'd1, 4'd0, cl);
      chk("clamp_flag", 4'(cl), 4'd1);
      do_rd(2'd1, d);
      chk("clamp_rd", d, 4'd1);

      // starvation guard: debug held while wr/rd keep requesting
      wr_req = 1; wr_addr = 2'd3; wr_data = 4'd3;
      rd_req = 1; rd_addr = 2'd3;
      dbg_req = 1; dbg_addr = 2'd3;
      g = 0; g_dbg = 0;
      for (int t = 0; t < 12 && g_dbg == 0; t++) begin
         tick();
         if (wr_ack || rd_ack || dbg_ack) g++;
         if (dbg_ack) g_dbg = g;
      end
      wr_req = 0; rd_req = 0; dbg_req = 0;
      chk("starve_grant", 4'(g_dbg), 4'd4);
      repeat (2) tick();

      // restore arriving during SERVE_RD is deferred, not lost
      rd_req = 1; rd_addr = 2'd2;
      tick();
      chk("rst_rd_ack", 4'(rd_ack), 4'd1);
      chk("rst_rd_data", rd_data, 4'd9);
      restore = 1; rd_req = 0;
      tick();
      restore = 0;
      tick();
      chk("restore_no_ack", 4'(rd_ack | wr_ack | dbg_ack), 4'd0);
      chk("restore_pc_lo", 4'(param_changed), 4'd0);
      tick();
      chk("restore_pc_hi", 4'(param_changed), 4'd1);
      tick();
      do_rd(2'd2, d);
      chk("restored_rd", d, 4'd2);

      // async reset in the middle of a write
      do_wr(2'd0, 4'd15, cl);
      wr_req = 1; wr_addr = 2'd3; wr_data = 4'd12;
      tick();
      sys_reset_n = 0;
      wr_req = 0;
      #1;
      chk("reset_abort_ack", 4'(wr_ack), 4'd0);
      repeat (2) tick();
      sys_reset_n = 1;
      tick();
      do_dbg(2'd0, d, lat);
      chk("reset_store0", d, 4'd6);
      do_dbg(2'd3, d, lat);
      chk("reset_store3", d, 4'd3);

      // randomized traffic with requester protocol and occasional restores
      for (int c = 0; c < 3000; c++) begin
         tick();
         restore = 0;
         if (wr_req) begin
            if (wr_ack || $urandom_range(31) == 0) wr_req = 0;
         end else if ($urandom_range(2) == 0) begin
            wr_req = 1; wr_addr = 2'($urandom);
            wr_data = ($urandom_range(3) == 0) ? 4'd0 : 4'($urandom);
         end
         if (rd_req) begin
            if (rd_ack || $urandom_range(31) == 0) rd_req = 0;
         end else if ($urandom_range(2) == 0) begin
            rd_req = 1; rd_addr = 2'($urandom);
         end
         if (dbg_req) begin
            if (dbg_ack || $urandom_range(31) == 0) dbg_req = 0;
         end else if ($urandom_range(3) == 0) begin
            dbg_req = 1; dbg_addr = 2'($urandom);
         end
         if (m_kind != K_RST && $urandom_range(39) == 0) restore = 1;
      end
      restore = 0; wr_req = 0; rd_req = 0; dbg_req = 0;
      repeat (4) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
